// File: rtl/usb_fs_in_buf.sv
// -----------------------------------------------------------------------------
// usb_fs_in_buf
//
// Single-endpoint IN packet buffer for a USB full-speed device. It sits just
// upstream of the transmitter. Endpoint logic writes up to MAX_PKT_SIZE bytes
// and then commits them as one packet. Each IN token produces one of three
// responses:
//   - DATA0 or DATA1, carrying the committed payload;
//   - NAK, when nothing is committed yet;
//   - STALL, when the endpoint is halted.
// The payload is kept until the host ACKs it, so a retry or an ACK timeout
// resends identical data with the same toggle.
//
// Ports
//   clk_48mhz      : 48 MHz clock, the only clock
//   reset          : synchronous, active-high
//   wr_en/wr_data  : byte write, accepted when wr_en && wr_ready
//   wr_commit      : pulse, current contents become a packet
//   wr_ready       : buffer is accepting writes
//   wr_overflow    : sticky, a write was dropped on a full buffer
//   in_token       : pulse, IN token for this endpoint
//   ack_rcvd       : pulse, host ACK decoded
//   stall          : level, endpoint halted
//   toggle_reset   : pulse, force data toggle to DATA0
//   tx_pkt_start   : one-cycle pulse to the transmitter
//   tx_pid         : PID, valid while tx_pkt_start is high
//   tx_data_avail  : payload bytes remain
//   tx_data_get    : pulse, transmitter consumed tx_data
//   tx_data        : current payload byte
//   tx_pkt_end     : pulse, transmitter finished the packet
//   toggle         : current data toggle (0 = DATA0)
// -----------------------------------------------------------------------------
module usb_fs_in_buf #(
  parameter int MAX_PKT_SIZE = 64,
  parameter int ACK_TIMEOUT  = 96
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_commit,
  output logic       wr_ready,
  output logic       wr_overflow,
  input  logic       in_token,
  input  logic       ack_rcvd,
  input  logic       stall,
  input  logic       toggle_reset,
  output logic       tx_pkt_start,
  output logic [3:0] tx_pid,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data,
  input  logic       tx_pkt_end,
  output logic       toggle
);

  localparam int AW = $clog2(MAX_PKT_SIZE);
  // One extra bit so that a full count of MAX_PKT_SIZE does not wrap.
  localparam int PW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_READY,
    ST_SENDING,
    ST_WAIT_ACK
  } state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] pkt_len_reg, pkt_len_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          toggle_reg, toggle_next;
  logic          overflow_reg, overflow_next;
  logic          hs_busy_reg, hs_busy_next;
  logic          pkt_start_reg, pkt_start_next;
  logic [3:0]    pid_reg, pid_next;
  logic [7:0]    tx_data_reg;
  logic          rd_load;

  logic [7:0]    mem [MAX_PKT_SIZE];

  logic          buf_full;
  logic          wr_accept;
  logic          wr_drop;
  logic          link_busy;
  logic          token_ok;
  logic          ack_timeout;
  logic [3:0]    data_pid;
  logic [AW-1:0] rd_addr;

  assign buf_full  = (wr_ptr_reg == PW'(MAX_PKT_SIZE));
  assign wr_accept = (state_reg == ST_FILL) && wr_en && !buf_full && !reset;
  assign wr_drop   = (state_reg == ST_FILL) && wr_en && buf_full;

  // A packet is on the wire while a handshake is outstanding or data is being
  // sent. Tokens arriving then are dropped, so a second tx_pkt_start can never
  // precede the previous tx_pkt_end.
  assign link_busy = hs_busy_reg || (state_reg == ST_SENDING);
  assign token_ok  = in_token && !link_busy;

  // This is the last WAIT_ACK cycle. An ACK sampled now is still honoured.
  assign ack_timeout = (state_reg == ST_WAIT_ACK) &&
                       (timer_reg == TW'(ACK_TIMEOUT - 1));

  // A toggle_reset that arrives together with a token already selects DATA0.
  assign data_pid = (toggle_reg && !toggle_reset) ? PID_DATA1 : PID_DATA0;

  // The read address follows the next pointer. Because the RAM read is
  // registered, tx_data is therefore valid in the same cycle as
  // tx_pkt_start and in the cycle after each tx_data_get.
  assign rd_addr = rd_ptr_next[AW-1:0];

  always_comb begin
    state_next     = state_reg;
    wr_ptr_next    = wr_ptr_reg + PW'(wr_accept);
    pkt_len_next   = pkt_len_reg;
    rd_ptr_next    = rd_ptr_reg;
    timer_next     = timer_reg;
    toggle_next    = toggle_reg;
    overflow_next  = overflow_reg;
    hs_busy_next   = hs_busy_reg;
    pkt_start_next = 1'b0;
    pid_next       = pid_reg;
    rd_load        = 1'b0;

    // The end of a NAK or STALL only frees the link. It never moves the
    // data state machine.
    if (hs_busy_reg && tx_pkt_end) begin
      hs_busy_next = 1'b0;
    end

    if (wr_drop) begin
      overflow_next = 1'b1;
    end

    unique case (state_reg)
      ST_FILL: begin
        if (wr_commit) begin
          pkt_len_next  = wr_ptr_reg + PW'(wr_accept);
          overflow_next = 1'b0;
          state_next    = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      ST_SENDING: begin
        if (tx_data_get && (rd_ptr_reg != pkt_len_reg)) begin
          rd_ptr_next = rd_ptr_reg + PW'(1);
          rd_load     = 1'b1;
        end
        if (tx_pkt_end) begin
          state_next = ST_WAIT_ACK;
          timer_next = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (ack_rcvd) begin
          toggle_next = ~toggle_reg;
          wr_ptr_next = '0;
          state_next  = ST_FILL;
        end else if (ack_timeout) begin
          state_next = ST_READY;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase

    if (token_ok) begin
      if (stall) begin
        pkt_start_next = 1'b1;
        pid_next       = PID_STALL;
        hs_busy_next   = 1'b1;
      end else if (state_reg == ST_FILL) begin
        // Also covers a commit in the same cycle: that token is still NAKed.
        pkt_start_next = 1'b1;
        pid_next       = PID_NAK;
        hs_busy_next   = 1'b1;
      end else if ((state_reg == ST_READY) ||
                   ((state_reg == ST_WAIT_ACK) && !ack_rcvd && !ack_timeout)) begin
        // A token on the timeout cycle is lost. The host retries.
        pkt_start_next = 1'b1;
        pid_next       = data_pid;
        rd_ptr_next    = '0;
        rd_load        = 1'b1;
        state_next     = ST_SENDING;
      end
    end

    // toggle_reset has the last word, so it also beats a simultaneous ACK.
    if (toggle_reset) begin
      toggle_next = 1'b0;
    end
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_reg     <= ST_FILL;
      wr_ptr_reg    <= '0;
      pkt_len_reg   <= '0;
      rd_ptr_reg    <= '0;
      timer_reg     <= '0;
      toggle_reg    <= 1'b0;
      overflow_reg  <= 1'b0;
      hs_busy_reg   <= 1'b0;
      pkt_start_reg <= 1'b0;
      pid_reg       <= 4'd0;
      tx_data_reg   <= 8'd0;
    end else begin
      state_reg     <= state_next;
      wr_ptr_reg    <= wr_ptr_next;
      pkt_len_reg   <= pkt_len_next;
      rd_ptr_reg    <= rd_ptr_next;
      timer_reg     <= timer_next;
      toggle_reg    <= toggle_next;
      overflow_reg  <= overflow_next;
      hs_busy_reg   <= hs_busy_next;
      pkt_start_reg <= pkt_start_next;
      pid_reg       <= pid_next;
      if (rd_load) begin
        tx_data_reg <= mem[rd_addr];
      end
    end
  end

  // Write port of the payload RAM. It has no reset.
  always_ff @(posedge clk_48mhz) begin
    if (wr_accept) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  assign wr_ready      = (state_reg == ST_FILL) && !reset;
  assign wr_overflow   = overflow_reg;
  assign tx_pkt_start  = pkt_start_reg;
  assign tx_pid        = pid_reg;
  assign tx_data_avail = (state_reg == ST_SENDING) && (rd_ptr_reg != pkt_len_reg);
  assign tx_data       = tx_data_reg;
  assign toggle        = toggle_reg;

endmodule

// File: tb/tb_usb_fs_in_buf.sv
module tb_usb_fs_in_buf;

  localparam int MAXP = 64;
  localparam int TMO  = 96;
  localparam logic [3:0] P_D0    = 4'b0011;
  localparam logic [3:0] P_D1    = 4'b1011;
  localparam logic [3:0] P_NAK   = 4'b1010;
  localparam logic [3:0] P_STALL = 4'b1110;

  logic       clk_48mhz;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       wr_commit;
  logic       wr_ready;
  logic       wr_overflow;
  logic       in_token;
  logic       ack_rcvd;
  logic       stall;
  logic       toggle_reset;
  logic       tx_pkt_start;
  logic [3:0] tx_pid;
  logic       tx_data_avail;
  logic       tx_data_get;
  logic [7:0] tx_data;
  logic       tx_pkt_end;
  logic       toggle;

  usb_fs_in_buf #(.MAX_PKT_SIZE(MAXP), .ACK_TIMEOUT(TMO)) dut (
    .clk_48mhz    (clk_48mhz),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_commit    (wr_commit),
    .wr_ready     (wr_ready),
    .wr_overflow  (wr_overflow),
    .in_token     (in_token),
    .ack_rcvd     (ack_rcvd),
    .stall        (stall),
    .toggle_reset (toggle_reset),
    .tx_pkt_start (tx_pkt_start),
    .tx_pid       (tx_pid),
    .tx_data_avail(tx_data_avail),
    .tx_data_get  (tx_data_get),
    .tx_data      (tx_data),
    .tx_pkt_end   (tx_pkt_end),
    .toggle       (toggle)
  );

  initial clk_48mhz = 1'b0;
  always #10 clk_48mhz = ~clk_48mhz;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: bytes written so far, the committed payload, the toggle
  // and the sticky overflow flag.
  logic [7:0] m_buf[$];
  logic [7:0] exp_q[$];
  bit         m_toggle;
  bit         m_ovf;

  typedef struct {
    int         len;
    bit         trst;
    bit         retry;
    logic [3:0] exp_pid;
    bit         exp_toggle;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [3:0] pid_of(bit t);
    return t ? P_D1 : P_D0;
  endfunction

  task automatic tick();
    @(posedge clk_48mhz);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    if (m_buf.size() < MAXP) m_buf.push_back(b);
    else m_ovf = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic write_rand(input int n);
    for (int i = 0; i < n; i++) write_byte(8'($urandom));
  endtask

  task automatic commit_pkt();
    wr_commit = 1'b1;
    tick();
    wr_commit = 1'b0;
    exp_q = m_buf;
    m_buf.delete();
    m_ovf = 1'b0;
    check("commit_wr_ready", wr_ready, 0);
    check("commit_overflow", wr_overflow, 0);
    $display("commit: %0d bytes", exp_q.size());
  endtask

  // Requests a data packet, drains it and compares it with exp_q.
  task automatic send_data(input logic [3:0] pid);
    int n;
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    check("data_start", tx_pkt_start, 1);
    check("data_pid", tx_pid, pid);
    check("data_avail_at_start", tx_data_avail, (exp_q.size() != 0));
    tick();
    check("data_start_one_cycle", tx_pkt_start, 0);
    n = 0;
    while (tx_data_avail && n < MAXP + 4) begin
      if (n < exp_q.size()) check("data_byte", tx_data, exp_q[n]);
      tx_data_get = 1'b1;
      tick();
      tx_data_get = 1'b0;
      n++;
    end
    check("data_len", n, exp_q.size());
    // An extra get after the last byte is ignored.
    tx_data_get = 1'b1;
    tick();
    tx_data_get = 1'b0;
    check("data_extra_get", tx_data_avail, 0);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    $display("data packet: pid=%b len=%0d", pid, n);
  endtask

  // Requests a NAK or STALL handshake and waits for the end of the packet.
  task automatic send_hs(input logic [3:0] pid);
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    check("hs_start", tx_pkt_start, 1);
    check("hs_pid", tx_pid, pid);
    check("hs_avail", tx_data_avail, 0);
    tick();
    check("hs_start_one_cycle", tx_pkt_start, 0);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    $display("handshake: pid=%b", pid);
  endtask

  task automatic do_ack(input bit trst);
    ack_rcvd     = 1'b1;
    toggle_reset = trst;
    tick();
    ack_rcvd     = 1'b0;
    toggle_reset = 1'b0;
    m_toggle = trst ? 1'b0 : ~m_toggle;
    check("ack_toggle", toggle, m_toggle);
    check("ack_wr_ready", wr_ready, 1);
    $display("ack: trst=%0d toggle=%0d", trst, toggle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len: 3,  trst: 0, retry: 0, exp_pid: P_D0, exp_toggle: 1};
    vecs[1] = '{len: 1,  trst: 0, retry: 0, exp_pid: P_D1, exp_toggle: 0};
    vecs[2] = '{len: 0,  trst: 0, retry: 0, exp_pid: P_D0, exp_toggle: 1};
    vecs[3] = '{len: 8,  trst: 0, retry: 1, exp_pid: P_D1, exp_toggle: 0};
    vecs[4] = '{len: 5,  trst: 0, retry: 0, exp_pid: P_D0, exp_toggle: 1};
    vecs[5] = '{len: 2,  trst: 1, retry: 0, exp_pid: P_D0, exp_toggle: 1};
    vecs[6] = '{len: 64, trst: 0, retry: 0, exp_pid: P_D1, exp_toggle: 0};

    reset = 1'b1; wr_en = 0; wr_data = 0; wr_commit = 0; in_token = 0;
    ack_rcvd = 0; stall = 0; toggle_reset = 0; tx_data_get = 0; tx_pkt_end = 0;
    m_toggle = 0; m_ovf = 0;
    repeat (3) tick();
    check("reset_wr_ready_low", wr_ready, 0);
    check("reset_start", tx_pkt_start, 0);
    check("reset_pid", tx_pid, 0);
    check("reset_avail", tx_data_avail, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_toggle", toggle, 0);
    check("reset_overflow", wr_overflow, 0);
    reset = 1'b0;
    #1;
    check("post_reset_wr_ready", wr_ready, 1);
    tick();

    // Known bytes, DATA0 then DATA1.
    write_byte(8'h11); write_byte(8'h22); write_byte(8'h33);
    commit_pkt();
    send_data(P_D0);
    do_ack(1'b0);
    write_byte(8'h44);
    commit_pkt();
    send_data(P_D1);
    do_ack(1'b0);

    // Table-driven packets.
    for (int v = 0; v < 7; v++) begin
      write_rand(vecs[v].len);
      commit_pkt();
      if (vecs[v].trst) begin
        toggle_reset = 1'b1;
        tick();
        toggle_reset = 1'b0;
        m_toggle = 1'b0;
        check("vec_trst_toggle", toggle, 0);
      end
      send_data(vecs[v].exp_pid);
      if (vecs[v].retry) send_data(vecs[v].exp_pid);
      do_ack(1'b0);
      check("vec_toggle", toggle, vecs[v].exp_toggle);
    end

    // NAK in FILL. A second token before tx_pkt_end gives no pulse.
    write_rand(2);
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    check("nak_start", tx_pkt_start, 1);
    check("nak_pid", tx_pid, P_NAK);
    check("nak_avail", tx_data_avail, 0);
    tick();
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    check("nak_second_token", tx_pkt_start, 0);
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    check("nak_wr_ready", wr_ready, 1);
    commit_pkt();
    send_data(pid_of(m_toggle));
    do_ack(1'b0);

    // A commit and a token in the same cycle: the commit is taken and the
    // token is NAKed.
    write_rand(2);
    wr_commit = 1'b1;
    in_token  = 1'b1;
    tick();
    wr_commit = 1'b0;
    in_token  = 1'b0;
    exp_q = m_buf;
    m_buf.delete();
    check("commit_tok_start", tx_pkt_start, 1);
    check("commit_tok_pid", tx_pid, P_NAK);
    tick();
    tx_pkt_end = 1'b1;
    tick();
    tx_pkt_end = 1'b0;
    send_data(pid_of(m_toggle));
    do_ack(1'b0);

    // STALL while READY, then the original packet is sent intact.
    write_rand(3);
    commit_pkt();
    stall = 1'b1;
    send_hs(P_STALL);
    stall = 1'b0;
    send_data(pid_of(m_toggle));
    do_ack(1'b0);

    // ACK timeout. An ACK in cycle TMO+1 is ignored, and the packet can be
    // requested again. An ACK in cycle TMO is still accepted.
    write_rand(4);
    commit_pkt();
    send_data(pid_of(m_toggle));
    repeat (TMO) tick();
    ack_rcvd = 1'b1;
    tick();
    ack_rcvd = 1'b0;
    check("late_ack_ignored", toggle, m_toggle);
    check("late_ack_wr_ready", wr_ready, 0);
    send_data(pid_of(m_toggle));
    repeat (TMO - 1) tick();
    do_ack(1'b0);

    // Overflow: 65 writes keep 64 bytes.
    write_rand(MAXP + 1);
    check("overflow_set", wr_overflow, m_ovf);
    check("overflow_wr_ready", wr_ready, 1);
    commit_pkt();
    send_data(pid_of(m_toggle));
    do_ack(1'b0);

    // Randomised packets checked against the model.
    for (int r = 0; r < 24; r++) begin
      int  len;
      bit  trst;
      len = $urandom_range(0, 70);
      write_rand(len);
      if ($urandom_range(0, 3) == 0) send_hs(P_NAK);
      check("rand_overflow", wr_overflow, m_ovf);
      commit_pkt();
      send_data(pid_of(m_toggle));
      if ($urandom_range(0, 2) == 0) send_data(pid_of(m_toggle));
      trst = ($urandom_range(0, 3) == 0);
      do_ack(trst);
    end

    // Reset while SENDING. Make the toggle 1 first, so that clearing it is
    // visible.
    if (!m_toggle) begin
      commit_pkt();
      send_data(P_D0);
      do_ack(1'b0);
    end
    write_rand(4);
    commit_pkt();
    in_token = 1'b1;
    tick();
    in_token = 1'b0;
    tx_data_get = 1'b1;
    tick();
    tx_data_get = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_send_start", tx_pkt_start, 0);
    check("rst_send_pid", tx_pid, 0);
    check("rst_send_avail", tx_data_avail, 0);
    check("rst_send_data", tx_data, 0);
    check("rst_send_toggle", toggle, 0);
    check("rst_send_wr_ready", wr_ready, 0);
    reset = 1'b0;
    m_toggle = 1'b0;
    m_buf.delete();
    #1;
    check("rst_send_ready_after", wr_ready, 1);
    tick();
    write_rand(3);
    commit_pkt();
    send_data(P_D0);
    do_ack(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
